// File: rtl/rtc_calendar_pkg.sv
// rtc_calendar_pkg: constants and types shared by the RTC calendar block.
//   - Field-select codes for the set bus (SEL_SEC..SEL_YEAR); codes 6 and 7 are illegal.
//   - Field widths and field maximum values.
//   - Packed time record used for the calendar state, plus its reset value.
package rtc_calendar_pkg;

    localparam int unsigned SEL_W  = 3;
    localparam int unsigned VAL_W  = 7;
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HOUR_W = 5;
    localparam int unsigned DAY_W  = 5;
    localparam int unsigned MON_W  = 4;
    localparam int unsigned YEAR_W = 7;

    localparam logic [SEL_W-1:0] SEL_SEC   = 3'd0;
    localparam logic [SEL_W-1:0] SEL_MIN   = 3'd1;
    localparam logic [SEL_W-1:0] SEL_HOUR  = 3'd2;
    localparam logic [SEL_W-1:0] SEL_DAY   = 3'd3;
    localparam logic [SEL_W-1:0] SEL_MONTH = 3'd4;
    localparam logic [SEL_W-1:0] SEL_YEAR  = 3'd5;

    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned MON_MAX  = 12;
    localparam int unsigned YEAR_MAX = 99;

    typedef struct packed {
        logic [YEAR_W-1:0] year;
        logic [MON_W-1:0]  month;
        logic [DAY_W-1:0]  day;
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  minute;
        logic [SEC_W-1:0]  second;
    } rtc_time_t;

    // 2000-01-01 00:00:00
    localparam rtc_time_t RTC_RESET = '{
        year:   '0,
        month:  MON_W'(1),
        day:    DAY_W'(1),
        hour:   '0,
        minute: '0,
        second: '0
    };

endpackage

// File: rtl/rtc_calendar_if.sv
// rtc_calendar_if: field-write bus of the RTC calendar.
//   set_en  - single-cycle write strobe
//   set_sel - field select (see SEL_* in rtc_calendar_pkg)
//   set_val - binary value to write
//   set_err - one-cycle pulse, one cycle after a rejected write
// master: the agent issuing writes; slave: the calendar.
interface rtc_calendar_if;
    import rtc_calendar_pkg::*;

    logic             set_en;
    logic [SEL_W-1:0] set_sel;
    logic [VAL_W-1:0] set_val;
    logic             set_err;

    modport master (
        output set_en,
        output set_sel,
        output set_val,
        input  set_err
    );

    modport slave (
        input  set_en,
        input  set_sel,
        input  set_val,
        output set_err
    );

endinterface

// File: rtl/rtc_dim.sv
// rtc_dim: combinational days-in-month lookup.
//   month - 1..12 (anything else reports 31)
//   year  - years since 2000; every year divisible by four is a leap year in 2000..2099
//   dim   - number of days in that month
module rtc_dim
    import rtc_calendar_pkg::*;
(
    input  logic [MON_W-1:0]  month,
    input  logic [YEAR_W-1:0] year,
    output logic [DAY_W-1:0]  dim
);

    logic leap;

    assign leap = ((year & YEAR_W'(3)) == '0);

    always_comb begin
        dim = DAY_W'(31);
        case (month)
            4'd2:                     dim = leap ? DAY_W'(29) : DAY_W'(28);
            4'd4, 4'd6, 4'd9, 4'd11:  dim = DAY_W'(30);
            default:                  dim = DAY_W'(31);
        endcase
    end

endmodule

// File: rtl/rtc_calendar.sv
// rtc_calendar: real-time clock/calendar (2000..2099) with a 1 Hz prescaler.
//   clk      - system clock, CLK_HZ Hz
//   rst      - asynchronous, active-high reset to 2000-01-01 00:00:00
//   set_bus  - field-write bus (slave side): set_en/set_sel/set_val in, set_err out
//   tick_1hz - one-cycle pulse, high in the cycle the new second is visible
//   year, month, day, hour, minute, second - registered binary time fields
module rtc_calendar
    import rtc_calendar_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    rtc_calendar_if.slave     set_bus,
    output logic              tick_1hz,
    output logic [YEAR_W-1:0] year,
    output logic [MON_W-1:0]  month,
    output logic [DAY_W-1:0]  day,
    output logic [HOUR_W-1:0] hour,
    output logic [MIN_W-1:0]  minute,
    output logic [SEC_W-1:0]  second
);

    localparam int unsigned    PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]  PMAX = PW'(CLK_HZ - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          pend_q, pend_d;
    logic          tick_q, tick_d;
    logic          err_q, err_d;
    rtc_time_t     time_q, time_d;

    logic              tick;
    logic              tick_req;
    logic              do_tick;
    logic              val_ok;
    logic              wr_ok;
    logic              wr_sec;
    logic [DAY_W-1:0]  dim_cur;
    logic [DAY_W-1:0]  dim_chk;
    logic [MON_W-1:0]  chk_month;
    logic [YEAR_W-1:0] chk_year;

    assign tick = (presc_q == PMAX);

    // Days in the current month, used by the day->month carry.
    rtc_dim u_dim_cur (
        .month (time_q.month),
        .year  (time_q.year),
        .dim   (dim_cur)
    );

    // Date as it would be after the pending write; used for day range check and clamping.
    always_comb begin
        chk_month = time_q.month;
        chk_year  = time_q.year;
        if (set_bus.set_sel == SEL_MONTH) begin
            chk_month = set_bus.set_val[MON_W-1:0];
        end
        if (set_bus.set_sel == SEL_YEAR) begin
            chk_year = set_bus.set_val;
        end
    end

    rtc_dim u_dim_chk (
        .month (chk_month),
        .year  (chk_year),
        .dim   (dim_chk)
    );

    // Range check of the value offered on the set bus.
    always_comb begin
        val_ok = 1'b0;
        case (set_bus.set_sel)
            SEL_SEC:   val_ok = (set_bus.set_val <= VAL_W'(SEC_MAX));
            SEL_MIN:   val_ok = (set_bus.set_val <= VAL_W'(MIN_MAX));
            SEL_HOUR:  val_ok = (set_bus.set_val <= VAL_W'(HOUR_MAX));
            SEL_DAY:   val_ok = (set_bus.set_val != '0) &&
                                (set_bus.set_val <= VAL_W'(dim_chk));
            SEL_MONTH: val_ok = (set_bus.set_val != '0) &&
                                (set_bus.set_val <= VAL_W'(MON_MAX));
            SEL_YEAR:  val_ok = (set_bus.set_val <= VAL_W'(YEAR_MAX));
            default:   val_ok = 1'b0;
        endcase
    end

    // Write/tick arbitration. Any set_en cycle defers the advance; a deferred tick survives
    // back-to-back writes and is dropped only by an accepted seconds write, which restarts
    // the second anyway.
    always_comb begin
        wr_ok    = set_bus.set_en && val_ok;
        wr_sec   = wr_ok && (set_bus.set_sel == SEL_SEC);
        tick_req = tick || pend_q;
        do_tick  = tick_req && !set_bus.set_en;
        pend_d   = set_bus.set_en && tick_req && !wr_sec;
        err_d    = set_bus.set_en && !val_ok;
        tick_d   = do_tick;
        if (wr_sec || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Next calendar state: either one accepted write or a full one-edge carry cascade.
    always_comb begin
        time_d = time_q;
        if (wr_ok) begin
            case (set_bus.set_sel)
                SEL_SEC:   time_d.second = set_bus.set_val[SEC_W-1:0];
                SEL_MIN:   time_d.minute = set_bus.set_val[MIN_W-1:0];
                SEL_HOUR:  time_d.hour   = set_bus.set_val[HOUR_W-1:0];
                SEL_DAY:   time_d.day    = set_bus.set_val[DAY_W-1:0];
                SEL_MONTH: begin
                    time_d.month = set_bus.set_val[MON_W-1:0];
                    if (time_q.day > dim_chk) begin
                        time_d.day = dim_chk;
                    end
                end
                SEL_YEAR: begin
                    time_d.year = set_bus.set_val;
                    if (time_q.day > dim_chk) begin
                        time_d.day = dim_chk;
                    end
                end
                default: ;
            endcase
        end else if (do_tick) begin
            if (time_q.second != SEC_W'(SEC_MAX)) begin
                time_d.second = time_q.second + SEC_W'(1);
            end else begin
                time_d.second = '0;
                if (time_q.minute != MIN_W'(MIN_MAX)) begin
                    time_d.minute = time_q.minute + MIN_W'(1);
                end else begin
                    time_d.minute = '0;
                    if (time_q.hour != HOUR_W'(HOUR_MAX)) begin
                        time_d.hour = time_q.hour + HOUR_W'(1);
                    end else begin
                        time_d.hour = '0;
                        if (time_q.day != dim_cur) begin
                            time_d.day = time_q.day + DAY_W'(1);
                        end else begin
                            time_d.day = DAY_W'(1);
                            if (time_q.month != MON_W'(MON_MAX)) begin
                                time_d.month = time_q.month + MON_W'(1);
                            end else begin
                                time_d.month = MON_W'(1);
                                if (time_q.year != YEAR_W'(YEAR_MAX)) begin
                                    time_d.year = time_q.year + YEAR_W'(1);
                                end else begin
                                    time_d.year = '0;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            pend_q  <= 1'b0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
            time_q  <= RTC_RESET;
        end else begin
            presc_q <= presc_d;
            pend_q  <= pend_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
            time_q  <= time_d;
        end
    end

    assign set_bus.set_err = err_q;
    assign tick_1hz        = tick_q;
    assign year            = time_q.year;
    assign month           = time_q.month;
    assign day             = time_q.day;
    assign hour            = time_q.hour;
    assign minute          = time_q.minute;
    assign second          = time_q.second;

endmodule

// File: tb/tb_rtc_calendar.sv
// tb_rtc_calendar: self-checking bench for rtc_calendar at CLK_HZ = 4.
// The reference keeps time as seconds elapsed since 2000-01-01 00:00:00 and derives the
// calendar fields arithmetically; directed scenarios are followed by random writes.
module tb_rtc_calendar;
    import rtc_calendar_pkg::*;

    localparam int unsigned HZ     = 4;
    localparam longint      DAY_S  = 86400;
    localparam longint      CENT_S = longint'(36525) * DAY_S;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz;
    logic [6:0] year;
    logic [3:0] month;
    logic [4:0] day;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;

    always #5 clk = ~clk;

    rtc_calendar_if bus ();

    rtc_calendar #(
        .CLK_HZ (HZ)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .set_bus  (bus),
        .tick_1hz (tick_1hz),
        .year     (year),
        .month    (month),
        .day      (day),
        .hour     (hour),
        .minute   (minute),
        .second   (second)
    );

    int     n_vec = 0;
    int     n_err = 0;

    // Reference state
    longint m_secs;
    int     m_cnt;
    bit     m_pend;
    bit     m_tick;
    bit     m_err;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint mdays(input longint m, input longint y);
        if (m == 2) return (y % 4 == 0) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    function automatic longint ydays(input longint y);
        return (y % 4 == 0) ? 366 : 365;
    endfunction

    function automatic longint to_secs(input longint y, input longint mo, input longint d,
                                       input longint h, input longint mi, input longint s);
        longint days = 0;
        for (longint i = 0; i < y; i++) days += ydays(i);
        for (longint i = 1; i < mo; i++) days += mdays(i, y);
        days += d - 1;
        return days * DAY_S + h * 3600 + mi * 60 + s;
    endfunction

    function automatic void from_secs(input longint t, output longint y, output longint mo,
                                      output longint d, output longint h, output longint mi,
                                      output longint s);
        longint days;
        s    = t % 60;
        mi   = (t / 60) % 60;
        h    = (t / 3600) % 24;
        days = t / DAY_S;
        y    = 0;
        while (days >= ydays(y)) begin
            days -= ydays(y);
            y++;
        end
        mo = 1;
        while (days >= mdays(mo, y)) begin
            days -= mdays(mo, y);
            mo++;
        end
        d = days + 1;
    endfunction

    function automatic longint pack6(input longint y, input longint mo, input longint d,
                                     input longint h, input longint mi, input longint s);
        return (y << 26) | (mo << 22) | (d << 17) | (h << 12) | (mi << 6) | s;
    endfunction

    function automatic longint model_pack();
        longint y, mo, d, h, mi, s;
        from_secs(m_secs, y, mo, d, h, mi, s);
        return pack6(y, mo, d, h, mi, s);
    endfunction

    function automatic longint dut_pack();
        logic [63:0] v;
        v = {31'd0, year, month, day, hour, minute, second};
        return longint'(v);
    endfunction

    function automatic void model_reset();
        m_secs = 0;
        m_cnt  = 0;
        m_pend = 1'b0;
        m_tick = 1'b0;
        m_err  = 1'b0;
    endfunction

    // One clock edge of the reference with the given set-bus inputs.
    function automatic void model_step(input bit en, input int sel, input int val);
        longint y, mo, d, h, mi, s;
        bit     tick, ok, adv;
        from_secs(m_secs, y, mo, d, h, mi, s);
        tick = (m_cnt == HZ - 1);
        ok   = 1'b0;
        if (en) begin
            case (sel)
                0:       ok = (val <= 59);
                1:       ok = (val <= 59);
                2:       ok = (val <= 23);
                3:       ok = (val >= 1) && (val <= mdays(mo, y));
                4:       ok = (val >= 1) && (val <= 12);
                5:       ok = (val <= 99);
                default: ok = 1'b0;
            endcase
        end
        m_err  = en && !ok;
        adv    = (tick || m_pend) && !en;
        m_pend = en && (tick || m_pend) && !(ok && sel == 0);
        m_cnt  = ((ok && sel == 0) || tick) ? 0 : m_cnt + 1;
        if (ok) begin
            case (sel)
                0:       s  = val;
                1:       mi = val;
                2:       h  = val;
                3:       d  = val;
                4:       mo = val;
                default: y  = val;
            endcase
            if (d > mdays(mo, y)) d = mdays(mo, y);
            m_secs = to_secs(y, mo, d, h, mi, s);
        end
        if (adv) m_secs = (m_secs + 1) % CENT_S;
        m_tick = adv;
    endfunction

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input bit en, input int sel, input int val);
        bus.set_en  = en;
        bus.set_sel = 3'(sel);
        bus.set_val = 7'(val);
        model_step(en, sel, val);
        @(posedge clk);
        #1;
        check("time", dut_pack(), model_pack());
        check("tick", longint'(tick_1hz), longint'(m_tick));
        check("err", longint'(bus.set_err), longint'(m_err));
        @(negedge clk);
    endtask

    task automatic wr(input int sel, input int val);
        step(1'b1, sel, val);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0);
    endtask

    task automatic wait_tick(input string tag);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 0, 0);
            if (tick_1hz) break;
        end
        check(tag, longint'(tick_1hz), 1);
    endtask

    task automatic set_all(input int y, input int mo, input int d, input int h, input int mi,
                           input int s);
        wr(5, y);
        wr(4, mo);
        wr(3, d);
        wr(2, h);
        wr(1, mi);
        wr(0, s);
    endtask

    initial begin
        rst         = 1'b1;
        bus.set_en  = 1'b0;
        bus.set_sel = '0;
        bus.set_val = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_time", dut_pack(), pack6(0, 1, 1, 0, 0, 0));
        check("rst_tick", longint'(tick_1hz), 0);
        check("rst_err", longint'(bus.set_err), 0);
        rst = 1'b0;

        // Free run from reset: ticks on the 4th and 8th edges.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 0, 0);
            check("run_tick", longint'(tick_1hz), (i == 3 || i == 7) ? 1 : 0);
        end
        check("run_sec", longint'(second), 2);

        // Century rollover in one edge.
        set_all(99, 12, 31, 23, 59, 59);
        wait_tick("roll_tick");
        check("roll_time", dut_pack(), pack6(0, 1, 1, 0, 0, 0));

        // Leap and non-leap February.
        set_all(4, 2, 28, 23, 59, 59);
        wait_tick("leap_tick");
        check("leap_day", longint'(day), 29);
        check("leap_mon", longint'(month), 2);
        set_all(5, 2, 28, 23, 59, 59);
        wait_tick("nonleap_tick");
        check("nonleap_mon", longint'(month), 3);
        check("nonleap_day", longint'(day), 1);

        // Day clamp on month change, then an out-of-range day write.
        wr(4, 1);
        wr(3, 31);
        wr(4, 4);
        check("clamp_mon", longint'(month), 4);
        check("clamp_day", longint'(day), 30);
        wr(3, 31);
        check("bad_day_err", longint'(bus.set_err), 1);
        check("bad_day_keep", longint'(day), 30);
        wr(6, 1);
        check("bad_sel_err", longint'(bus.set_err), 1);

        // Write colliding with a tick: tick deferred by one cycle.
        wr(0, 0);
        idle(3);
        wr(1, 10);
        check("coll_min", longint'(minute), 10);
        check("coll_tick0", longint'(tick_1hz), 0);
        idle(1);
        check("coll_tick1", longint'(tick_1hz), 1);
        check("coll_sec", longint'(second), 1);
        // Pending tick survives a second consecutive write.
        idle(2);
        wr(2, 5);
        wr(2, 6);
        check("hold_tick0", longint'(tick_1hz), 0);
        idle(1);
        check("hold_tick1", longint'(tick_1hz), 1);
        check("hold_sec", longint'(second), 2);
        // Seconds write discards the pending tick.
        idle(1);
        wr(0, 30);
        idle(1);
        check("drop_tick", longint'(tick_1hz), 0);
        check("drop_sec", longint'(second), 30);

        // Random writes against the reference.
        for (int i = 0; i < 600; i++) begin
            bit en;
            int sel, val;
            en  = ($urandom_range(0, 3) == 0);
            sel = int'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) begin
                case (sel)
                    0, 1:    val = 59;
                    2:       val = 23;
                    3:       val = int'($urandom_range(28, 31));
                    4:       val = 12;
                    5:       val = 99;
                    default: val = int'($urandom_range(0, 127));
                endcase
            end else if ($urandom_range(0, 1) == 0) begin
                val = int'($urandom_range(0, 31));
            end else begin
                val = int'($urandom_range(0, 127));
            end
            step(en, sel, val);
        end

        // Asynchronous reset mid-count.
        set_all(0, 5, 5, 12, 30, 30);
        idle(2);
        rst        = 1'b1;
        bus.set_en = 1'b1;
        #1;
        check("arst_time", dut_pack(), pack6(0, 1, 1, 0, 0, 0));
        check("arst_tick", longint'(tick_1hz), 0);
        check("arst_err", longint'(bus.set_err), 0);
        model_reset();
        #1;
        rst        = 1'b0;
        bus.set_en = 1'b0;
        idle(5);
        check("arst_sec", longint'(second), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rtc_calendar.md
RTC_CALENDAR -- requirements
Module: rtc_calendar

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, meaning input clock frequency in Hz; legal range >= 2.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port set_en  input  1  single-cycle write strobe for one time field.
REQ-005 SHALL have port set_sel  input  3  field select: 0=second, 1=minute, 2=hour, 3=day, 4=month, 5=year; 6 and 7 illegal.
REQ-006 SHALL have port set_val  input  7  binary value to write.
REQ-007 SHALL have port set_err  output  1  one-cycle pulse; write rejected.
REQ-008 SHALL have port tick_1hz  output  1  one-cycle pulse on each second advance.
REQ-009 SHALL have port year  output  7  years since 2000, 0..99.
REQ-010 SHALL have port month  output  4  1..12.
REQ-011 SHALL have port day  output  5  1..days_in_month.
REQ-012 SHALL have port hour  output  5  0..23.
REQ-013 SHALL have port minute  output  6  0..59.
REQ-014 SHALL have port second  output  6  0..59; all time outputs are registered, binary, and drive the bin2BCD stages directly.

Function
REQ-015 Prescaler SHALL count 0..CLK_HZ-1 and raise internal tick when at CLK_HZ-1, then wrap to 0.
REQ-016 On tick, second SHALL increment by 1 in the same edge, with tick_1hz high for exactly that cycle.
REQ-017 Cascade SHALL be second 59->0 carry minute; minute 59->0 carry hour; hour 23->0 carry day; day==dim->1 carry month; month 12->1 carry year; year 99->0 with no further carry.
REQ-018 dim SHALL be 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; 29 for Feb if year[1:0]==0, else 28.
REQ-019 Full cascade, for example 99-12-31 23:59:59 to 00-01-01 00:00:00, SHALL complete in one clock edge.
REQ-020 Write SHALL be accepted when set_en=1, set_sel<=5, and set_val is in range for that field, with day range checked against dim of current month/year; the field updates at the next edge.
REQ-021 Illegal set_sel or out-of-range set_val SHALL leave all fields unchanged and pulse set_err one cycle after set_en.
REQ-022 Writing second SHALL also clear the prescaler to 0.
REQ-023 After an accepted month or year write, if day > new dim, day SHALL clamp to new dim on the same edge.
REQ-024 When set_en and tick occur in the same cycle, the write SHALL apply and the tick SHALL be held pending and applied on the next cycle, delaying tick_1hz by one cycle; a pending tick SHALL be discarded if the write was to second.
REQ-025 A pending tick SHALL not be lost if set_en is asserted again in the following cycle; it stays pending until a cycle without set_en.

Reset
REQ-026 Asserting rst SHALL immediately force: prescaler 0, pending tick 0, second 0, minute 0, hour 0, day 1, month 1, year 0, tick_1hz 0, set_err 0.
REQ-027 A write or tick in progress when rst asserts SHALL be abandoned; counting resumes on the first edge after rst deasserts.

Structure
REQ-028 The shared package SHALL hold field-select constants (SEL_SEC..SEL_YEAR), field widths, and field max constants (59, 23, 12, 99).
REQ-029 Days-in-month SHALL be a single combinational sub-module rtc_dim (inputs month and year, output 5-bit dim), instantiated twice: once for the current date and once for the clamp/check date.

Verification (bench uses CLK_HZ=4)
REQ-030 Scenario: reset, then run 8 clocks -> tick_1hz pulses at clocks 4 and 8, and second reads 2.
REQ-031 Scenario: set 99-12-31 23:59:59, then one tick -> all fields read 0,1,1,0,0,0 on the tick edge.
REQ-032 Scenario: year=4, month=2, day=28 23:59:59, then tick -> day reads 29; repeat with year=5 -> month reads 3 and day reads 1.
REQ-033 Scenario: with day=31 in month 1, write month=4 -> month reads 4 and day reads 30; then write day=31 -> set_err pulses and day stays 30.
REQ-034 Scenario: set_en for minute=10 in the same cycle as a tick -> minute reads 10, and second increments and tick_1hz pulses one cycle later.
REQ-035 Scenario: assert rst mid-count at 00-05-05 12:30:30 -> outputs read 00-01-01 00:00:00 before the next clock edge.
